// File: rtl/synth_sample_sequencer_if.sv
// Sequencer <-> player/audio bundle. The sequencer drives through `master`;
// the player and timing side connect through `slave`.
interface synth_sample_sequencer_if #(
  parameter int PROG_ADDR_BITS      = 7,
  parameter int SAMPLE_COUNTER_BITS = 26,
  parameter int OCT_BITS            = 3,
  parameter int A_BITS              = 11
);
  logic                           run;
  logic                           pause_req;
  logic                           pause_ack;
  logic                           frame_sync;
  logic [PROG_ADDR_BITS-1:0]      program_addr;
  logic                           enable;
  logic                           sample_strobe;
  logic [SAMPLE_COUNTER_BITS-1:0] sample_counter;
  logic [2**OCT_BITS-2:0]         oct_counter;
  logic signed [A_BITS-1:0]       sample_in;
  logic                           audio_out;

  modport master (
    input  run, pause_req, frame_sync, sample_in,
    output pause_ack, program_addr, enable, sample_strobe,
           sample_counter, oct_counter, audio_out
  );

  modport slave (
    output run, pause_req, frame_sync, sample_in,
    input  pause_ack, program_addr, enable, sample_strobe,
           sample_counter, oct_counter, audio_out
  );
endinterface

// File: rtl/synth_sample_sequencer.sv
// Time-multiplexed synth sequencer: microprogram address/enable, sample timebase
// with frame resync and pause handshake, sample latch and dithered PWM output.
module synth_sample_sequencer #(
  parameter int PROG_LEN            = 100,
  parameter int PROG_ADDR_BITS      = 7,
  parameter int SAMPLE_COUNTER_BITS = 26,
  parameter int OCT_BITS            = 3,
  parameter int SYNC_BITS           = 4,
  parameter int A_BITS              = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  synth_sample_sequencer_if.master  bus
);

  localparam int PAB = PROG_ADDR_BITS;
  localparam int SCB = SAMPLE_COUNTER_BITS;
  localparam logic [PAB-1:0] LAST = PAB'(PROG_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, PAUSED} state_t;

  state_t           r_state, w_next;
  logic [PAB-1:0]   r_addr, w_addr_n;
  logic             r_en, r_strobe, r_ack, r_audio;
  logic [SCB-1:0]   r_cnt, w_cnt_hi, w_resync;
  logic [PAB-1:0]   r_pwm;
  logic             r_sync;
  logic             r_to_idle, w_to_idle;
  logic             w_active, w_last, w_next_active;

  assign w_active      = (r_state == RUN) || (r_state == DRAIN);
  assign w_last        = w_active && (r_addr == LAST);
  assign w_next_active = (w_next == RUN) || (w_next == DRAIN);
  assign w_cnt_hi      = r_cnt >> SYNC_BITS;
  assign w_resync      = (w_cnt_hi + SCB'(1)) << SYNC_BITS;

  // r_to_idle remembers that run dropped mid-sample, so a drain started by
  // run=0 still ends in IDLE even if run comes back before the boundary.
  always_comb begin
    w_next    = r_state;
    w_to_idle = r_to_idle;
    w_addr_n  = '0;
    case (r_state)
      IDLE: begin
        w_to_idle = 1'b0;
        if (bus.run && !bus.pause_req) w_next = RUN;
      end
      RUN, DRAIN: begin
        if (!bus.run) w_to_idle = 1'b1;
        if (w_last) begin
          if (w_to_idle)                                 w_next = IDLE;
          else if (r_state == DRAIN || bus.pause_req)    w_next = PAUSED;
          else                                           w_next = RUN;
        end else begin
          if (w_to_idle || bus.pause_req) w_next = DRAIN;
          w_addr_n = r_addr + PAB'(1);
        end
      end
      PAUSED: begin
        w_to_idle = 1'b0;
        if (!bus.run)            w_next = IDLE;
        else if (!bus.pause_req) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_en      <= 1'b0;
      r_strobe  <= 1'b0;
      r_ack     <= 1'b0;
      r_audio   <= 1'b0;
      r_cnt     <= '0;
      r_pwm     <= '0;
      r_sync    <= 1'b0;
      r_to_idle <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_addr    <= w_next_active ? w_addr_n : '0;
      r_en      <= w_next_active;
      r_strobe  <= w_next_active && (w_addr_n == LAST);
      r_ack     <= (w_next == PAUSED);
      r_to_idle <= (w_next == DRAIN) && w_to_idle;
      // Audio lags program_addr by one cycle and is silenced whenever the
      // sample stream is not running on both sides of the edge.
      r_audio   <= (w_active && w_next_active) ? ((r_pwm > r_addr) ^ ~r_cnt[0]) : 1'b0;
      if (w_last) begin
        r_pwm  <= bus.sample_in[PAB-1:0];
        r_cnt  <= r_sync ? w_resync : r_cnt + SCB'(1);
        r_sync <= bus.frame_sync;
      end else if (bus.frame_sync && r_state != IDLE) begin
        r_sync <= 1'b1;
      end
    end
  end

  generate
    if (A_BITS > PROG_ADDR_BITS) begin : g_unused_msbs
      logic w_unused_sample_msbs;
      assign w_unused_sample_msbs = ^bus.sample_in[A_BITS-1:PAB];
    end
  endgenerate

  assign bus.program_addr   = r_addr;
  assign bus.enable         = r_en;
  assign bus.sample_strobe  = r_strobe;
  assign bus.pause_ack      = r_ack;
  assign bus.sample_counter = r_cnt;
  assign bus.oct_counter    = r_cnt[2**OCT_BITS-2:0];
  assign bus.audio_out      = r_audio;

endmodule

// File: tb/tb_synth_sample_sequencer.sv
// Bench for synth_sample_sequencer: directed scenarios plus random run/pause/sync
// traffic, all compared each cycle against a sample-level behavioural model.
module tb_synth_sample_sequencer;
  localparam int PL   = 100;
  localparam int PAB  = 7;
  localparam int SCB  = 26;
  localparam int OCTB = 3;
  localparam int SB   = 4;
  localparam int AB   = 11;
  localparam int LASTA = PL - 1;
  localparam int unsigned CMASK = (1 << SCB) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  synth_sample_sequencer_if #(.PROG_ADDR_BITS(PAB), .SAMPLE_COUNTER_BITS(SCB),
                              .OCT_BITS(OCTB), .A_BITS(AB)) bus ();

  synth_sample_sequencer #(.PROG_LEN(PL), .PROG_ADDR_BITS(PAB), .SAMPLE_COUNTER_BITS(SCB),
                           .OCT_BITS(OCTB), .SYNC_BITS(SB), .A_BITS(AB))
    dut (.clk(clk), .reset(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // model: mode 0=idle 1=sample stream running 2=paused; stop 0=none 1=pause 2=idle
  int          m_mode, m_stop, m_addr;
  int unsigned m_cnt, m_pwm;
  bit          m_sync, m_audio;

  task automatic model_reset();
    m_mode = 0; m_stop = 0; m_addr = 0;
    m_cnt = 0; m_pwm = 0; m_sync = 0; m_audio = 0;
  endtask

  task automatic model_step(input bit r, input bit p, input bit f, input int unsigned s);
    bit act, last, lvl;
    int stop, nmode;
    act  = (m_mode == 1);
    last = act && (m_addr == LASTA);
    stop = m_stop;
    if (act) begin
      if (!r) stop = 2;
      else if (p && stop == 0) stop = 1;
    end
    if (m_mode == 0)      nmode = (r && !p) ? 1 : 0;
    else if (m_mode == 2) nmode = !r ? 0 : (!p ? 1 : 2);
    else if (last)        nmode = (stop == 2) ? 0 : (stop == 1) ? 2 : 1;
    else                  nmode = 1;
    lvl = (m_pwm > m_addr);
    m_audio = (act && nmode == 1) ? (m_cnt[0] ? lvl : !lvl) : 1'b0;
    if (last) begin
      m_cnt  = m_sync ? ((((m_cnt >> SB) + 1) << SB) & CMASK) : ((m_cnt + 1) & CMASK);
      m_pwm  = s % 128;
      m_sync = f;
    end else if (m_mode != 0 && f) begin
      m_sync = 1;
    end
    m_addr = (act && nmode == 1 && !last) ? m_addr + 1 : 0;
    m_stop = (nmode == 1 && !last) ? stop : 0;
    m_mode = nmode;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("program_addr", 32'(bus.program_addr), 32'(m_addr));
    chk("enable", 32'(bus.enable), 32'(m_mode == 1));
    chk("sample_strobe", 32'(bus.sample_strobe), 32'(m_mode == 1 && m_addr == LASTA));
    chk("pause_ack", 32'(bus.pause_ack), 32'(m_mode == 2));
    chk("sample_counter", 32'(bus.sample_counter), m_cnt);
    chk("oct_counter", 32'(bus.oct_counter), m_cnt % 128);
    chk("audio_out", 32'(bus.audio_out), 32'(m_audio));
  endtask

  // one clock: inputs applied at the falling edge, outputs checked at the next one
  task automatic cycle(input bit r, input bit p, input bit f, input int unsigned s);
    bus.run = r; bus.pause_req = p; bus.frame_sync = f; bus.sample_in = AB'(s);
    model_step(r, p, f, s);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to_addr(input int a, input bit p);
    int n;
    n = 0;
    while (!(m_mode == 1 && m_addr == a) && n < 400) begin
      cycle(1'b1, p, 1'b0, $urandom);
      n++;
    end
    chk("reach_addr_timeout", 32'(n < 400), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned saved;
    int n;
    bit ack_seen;
    bus.run = 0; bus.pause_req = 0; bus.frame_sync = 0; bus.sample_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // free run from reset release: 301 edges -> 3 samples done, addr back at 0
    for (int i = 0; i < 301; i++) cycle(1'b1, 1'b0, 1'b0, $urandom);
    chk("count_after_300", 32'(bus.sample_counter), 32'd3);
    chk("addr_after_300", 32'(bus.program_addr), 32'd0);

    // pause requested mid-sample
    run_to_addr(40, 1'b0);
    n = 0;
    while (m_mode != 2 && n < 200) begin cycle(1'b1, 1'b1, 1'b0, $urandom); n++; end
    chk("pause_reached", 32'(m_mode == 2 && n == 60), 32'd1);
    saved = m_cnt;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, $urandom);
    chk("paused_ack", 32'(bus.pause_ack), 32'd1);
    chk("paused_cnt", 32'(bus.sample_counter), saved);
    cycle(1'b1, 1'b0, 1'b0, $urandom);
    chk("resume_en", 32'(bus.enable), 32'd1);
    chk("resume_ack", 32'(bus.pause_ack), 32'd0);

    // PWM: latch 0x030 on two consecutive strobes to see both polarities
    for (int k = 0; k < 2; k++) begin
      run_to_addr(LASTA, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'h030);
    end
    for (int i = 0; i < PL; i++) cycle(1'b1, 1'b0, 1'b0, 32'h030);

    // resync: climb to 0x123 then pulse twice in one sample
    while (m_cnt < 32'h120) begin
      run_to_addr(10, 1'b0);
      cycle(1'b1, 1'b0, (m_cnt + 16 <= 32'h120), $urandom);
      run_to_addr(0, 1'b0);
    end
    while (m_cnt < 32'h123) begin
      run_to_addr(LASTA, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, $urandom);
    end
    chk("pre_resync", 32'(bus.sample_counter), 32'h123);
    run_to_addr(10, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, $urandom);
    run_to_addr(30, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, $urandom);
    run_to_addr(0, 1'b0);
    chk("resync_value", 32'(bus.sample_counter), 32'h130);

    // async reset mid-sample
    run_to_addr(57, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.program_addr), 32'd0);
    chk("arst_en", 32'(bus.enable), 32'd0);
    chk("arst_cnt", 32'(bus.sample_counter), 32'd0);
    chk("arst_audio", 32'(bus.audio_out), 32'd0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // run dropped together with pause_req
    run_to_addr(20, 1'b0);
    saved = m_cnt;
    ack_seen = 0;
    n = 0;
    while (m_mode != 0 && n < 200) begin
      cycle(1'b0, 1'b1, 1'b0, $urandom);
      ack_seen |= bus.pause_ack;
      n++;
    end
    chk("drop_idle_cycles", 32'(n), 32'd80);
    chk("drop_no_ack", 32'(ack_seen), 32'd0);
    chk("drop_cnt", 32'(bus.sample_counter), (saved + 1) & CMASK);

    // random traffic
    begin
      bit r, p;
      r = 1; p = 0;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(299) == 0) r = !r;
        if ($urandom_range(149) == 0) p = !p;
        cycle(r, p, ($urandom_range(49) == 0), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/synth_sample_sequencer.md
Name: synth_sample_sequencer

Overview:
- Sequences the time-multiplexed synth player.
- Generates the per-cycle microprogram address and enable, and advances the sample, octave and detune timebase once per sample period.
- Latches the finished player output and drives the dithered PWM audio pin.
- Sits between the top-level timing and the player. It replaces ad-hoc derivation of program_addr and sample_counter from video counters, and adds a pause handshake and frame-aligned resync.

Parameters:
- PROG_LEN, 100, clock cycles per sample; the microprogram length (≥2).
- PROG_ADDR_BITS, 7, width of program_addr; 2**PROG_ADDR_BITS ≥ PROG_LEN.
- SAMPLE_COUNTER_BITS, 26, width of sample_counter.
- OCT_BITS, 3, oct_counter width is 2**OCT_BITS-1.
- SYNC_BITS, 4, low sample_counter bits cleared by frame resync.
- A_BITS, 11, width of signed player sample.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- run, input, 1, level; 1 = sequencing allowed.
- pause_req, input, 1, level request to halt at the next sample boundary.
- pause_ack, output, 1, high while halted at a boundary.
- frame_sync, input, 1, one-cycle pulse requesting a frame-aligned sample counter.
- program_addr, output, PROG_ADDR_BITS, microprogram step to the player.
- enable, output, 1, player step enable.
- sample_strobe, output, 1, one-cycle pulse on the last step of each sample.
- sample_counter, output, SAMPLE_COUNTER_BITS, samples completed.
- oct_counter, output, 2**OCT_BITS-1, sample_counter[2**OCT_BITS-2:0].
- sample_in, input, A_BITS signed, player output; valid during the sample_strobe cycle.
- audio_out, output, 1, PWM audio.

Behaviour:
- Reset (reset low, async):
  - state=IDLE, program_addr=0, enable=0, sample_strobe=0, pause_ack=0.
  - sample_counter=0, latched sample=0, sync_pending=0, audio_out=0.
- States: IDLE, RUN, DRAIN, PAUSED.
- IDLE:
  - Outputs held at their reset values.
  - run=1 and pause_req=0 → RUN next cycle with program_addr=0.
- RUN:
  - enable=1.
  - program_addr increments every cycle and wraps from PROG_LEN-1 to 0.
  - sample_strobe=1 exactly while program_addr==PROG_LEN-1.
- Sample boundary (the cycle after a strobe):
  - Sample latch: on the strobe cycle, sample_in[PROG_ADDR_BITS-1:0] is captured as unsigned pwm_level.
  - Counter update: sample_counter increments by 1 on the strobe cycle, modulo 2**SAMPLE_COUNTER_BITS.
  - Resync: if sync_pending=1, sample_counter instead becomes ((sample_counter>>SYNC_BITS)+1)<<SYNC_BITS; sync_pending then clears.
  - frame_sync arriving on the strobe cycle itself is applied at the following boundary, not the current one.
- pause_req=1 in RUN:
  - If program_addr==PROG_LEN-1: complete the strobe normally, then PAUSED.
  - Otherwise: go to DRAIN. DRAIN behaves as RUN until its strobe cycle, then PAUSED.
  - Samples are never truncated.
- PAUSED:
  - enable=0, program_addr=0, pause_ack=1, audio_out=0.
  - sample_counter and pwm_level are held.
  - pause_req=0 → RUN next cycle; pause_ack drops in that same cycle.
- run=0 in any state:
  - Finish the current sample as in DRAIN, then IDLE.
  - sample_counter is kept, not cleared.
  - run=0 in PAUSED → IDLE immediately.
- pause_req and run=0 together: run=0 wins; the final state is IDLE and pause_ack stays 0.
- frame_sync:
  - Sets sync_pending in any state except IDLE.
  - A pulse while sync_pending is already set is absorbed.
- audio_out:
  - RUN/DRAIN: registered (pwm_level > program_addr) XOR !sample_counter[0], one cycle after program_addr.
  - IDLE/PAUSED: audio_out=0.
- All outputs are registered, except oct_counter, which is a wire slice of the registered sample_counter.

Test Plan:
- Reset release with run=1, pause_req=0, PROG_LEN=100:
  - program_addr counts 0..99 then 0.
  - sample_strobe high on the cycles with addr=99.
  - sample_counter=3 after 300 cycles.
- pause_req raised when addr=40:
  - program_addr continues to 99, strobes once, then PAUSED.
  - enable=0, pause_ack=1, program_addr=0, sample_counter unchanged thereafter.
  - Deasserting pause_req restarts at addr 0 next cycle.
- PWM: sample_in=0x030 latched, sample_counter even after update:
  - audio_out = NOT(0x30>addr) over the next period, i.e. low for addr 0..47, high for 48..99.
  - With sample_counter odd, the polarity inverts.
- Resync:
  - sample_counter=0x123, frame_sync pulsed at addr 10 → after the next strobe sample_counter=0x130 (not 0x124).
  - A second pulse in the same sample has no extra effect.
- Async reset asserted mid-sample (addr=57):
  - All outputs go to reset values immediately without a clock edge.
  - State=IDLE.
- run dropped at addr 20 with pause_req=1:
  - Sample completes to addr 99, state→IDLE, pause_ack never rises, sample_counter incremented once.
